alu_cmd_feeder: RTL and testbench
=================================

# alu_cmd_feeder

Upstream command stage for the 4-bit ALU. Accepts {MODE, A, B} commands over a valid/ready handshake and buffers them in a small FIFO. Issues one command at a time to the ALU through registered operand ports, then captures the 8-bit ALU result into a held output with its own valid/ready handshake. The ALU is a separate, purely combinational block, wired to this block at the top level.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  command present on IN_MODE/IN_A/IN_B.
- IN_READY  out  1  FIFO can accept; equals (COUNT < DEPTH), from registered state only.
- IN_MODE  in  2  ALU opcode: 00 add, 01 and, 10 greater-than, 11 shift-right.
- IN_A, IN_B  in  4 each  operands.
- ALU_MODE  out  2  registered opcode driven to the ALU.
- ALU_A, ALU_B  out  4 each  registered operands driven to the ALU.
- ALU_OUT  in  8  combinational ALU result.
- RES_VALID  out  1  RES_DATA/RES_MODE hold a result.
- RES_READY  in  1  downstream consumes the result.
- RES_DATA  out  8  captured ALU_OUT.
- RES_MODE  out  2  opcode that produced RES_DATA.
- COUNT  out  $clog2(DEPTH)+1  FIFO occupancy.
- BUSY  out  1  high whenever state ≠ IDLE.

## Operation
- Push: IN_VALID && IN_READY at an edge writes {IN_MODE, IN_A, IN_B} at the write pointer. There is no bypass; an empty FIFO still takes the full path.
- FSM states:
  - IDLE: if COUNT > 0, pop the head into ALU_MODE/ALU_A/ALU_B and go to EXEC; otherwise stay.
  - EXEC: capture ALU_OUT into RES_DATA and ALU_MODE into RES_MODE, set RES_VALID, go to HOLD.
  - HOLD: on RES_VALID && RES_READY, clear RES_VALID and go to IDLE; otherwise hold RES_* stable.
- ALU_* registers change only on a pop. They keep their last values in EXEC, HOLD and IDLE-empty.
- Simultaneous push and pop: COUNT unchanged, both pointers advance.
- Full (COUNT == DEPTH): IN_READY is low. A pop in the same cycle does not enable a push.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. COUNT saturates at neither end, because the handshake rules prevent overflow and underflow.
- Commands complete strictly in arrival order. None are dropped or reordered.
- The FIFO content itself does not need to be reset.
- Reset values: state IDLE, pointers 0, COUNT 0, IN_READY 1, RES_VALID 0, RES_DATA 8'h00, RES_MODE 2'b00, ALU_MODE 2'b00, ALU_A 4'h0, ALU_B 4'h0, BUSY 0.
- Reset mid-operation: in-flight and buffered commands are discarded. All outputs return to reset values immediately, asynchronously.

## Timing
- Command accepted at edge E0.
- If the feeder was idle with COUNT 0: ALU_* valid after E1, RES_VALID high after E2.
- With RES_READY held high, RES_VALID drops after E3. The next pop can occur at E4, so peak throughput is one result per 3 cycles.
- RES_READY has no combinational path to IN_READY or to any other output.
- The ALU path is one cycle: ALU_* register → ALU → RES_DATA register.

## Structure
- Shared package alu_pkg holds:
  - opcode constants MODE_ADD=2'b00, MODE_AND=2'b01, MODE_GT=2'b10, MODE_SHR=2'b11;
  - the command struct {mode[1:0], a[3:0], b[3:0]};
  - the feeder state enum {IDLE, EXEC, HOLD}.
- Sub-module alu_cmd_fifo, parameterised by DEPTH, provides push/pop/count/full/empty.
- The FSM and the result register live in alu_cmd_feeder.

## Test plan
- Single add, RES_READY=1: MODE 00, A=9, B=8. Expect ALU_A=9/ALU_B=8 one cycle after accept, then RES_DATA=8'h11 and RES_MODE=00 with RES_VALID high two cycles after accept for exactly one cycle.
- One command of each op, issued back-to-back:
  - 01 A=C B=A → 8'h08
  - 10 A=3 B=5 → 8'h00
  - 10 A=7 B=2 → 8'h01
  - 11 A=F B=2 → 8'h03
  - Results must arrive in this order, one every 3 cycles.
- Backpressure with RES_READY=0: push commands continuously. Exactly 1+DEPTH (=5) are accepted, then IN_READY stays low with COUNT=4. Releasing RES_READY drains all 5 in order with values intact.
- Pointer wrap: push and drain 11 commands with random operands. Every result must match the ALU op model, and COUNT must return to 0.
- Simultaneous push/pop: with COUNT=2, assert IN_VALID during the IDLE pop cycle. COUNT stays 2 and ordering is preserved.
- Reset mid-operation: assert RST while in HOLD with COUNT=3. All outputs return to reset values immediately and IN_READY is 1. After release, a new command MODE 00 A=1 B=1 yields 8'h02 with no stale results.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU command path: opcodes, the command word
// and the feeder sequencing states.
package alu_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_GT  = 2'b10;
    localparam logic [1:0] MODE_SHR = 2'b11;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] a;
        logic [3:0] b;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/alu_cmd_feeder_if.sv
// Bundle of the feeder's command, ALU and result signals. The slave modport
// is the feeder's view; the master modport is the surrounding system's view.
interface alu_cmd_feeder_if #(
    parameter int DEPTH = 4
) ();
    import alu_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_mode;
    logic [3:0]               in_a;
    logic [3:0]               in_b;

    logic [1:0]               alu_mode;
    logic [3:0]               alu_a;
    logic [3:0]               alu_b;
    logic [7:0]               alu_out;

    logic                     res_valid;
    logic                     res_ready;
    logic [7:0]               res_data;
    logic [1:0]               res_mode;

    logic [$clog2(DEPTH):0]   count;
    logic                     busy;

    modport slave (
        input  in_valid, in_mode, in_a, in_b, alu_out, res_ready,
        output in_ready, alu_mode, alu_a, alu_b, res_valid, res_data, res_mode,
               count, busy
    );

    modport master (
        output in_valid, in_mode, in_a, in_b, alu_out, res_ready,
        input  in_ready, alu_mode, alu_a, alu_b, res_valid, res_data, res_mode,
               count, busy
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Circular command buffer; occupancy is tracked explicitly so full and
// empty never depend on pointer comparison.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  alu_cmd_t                push_data,
    input  logic                    pop,
    output alu_cmd_t                pop_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    alu_cmd_t          mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/alu_cmd_feeder.sv
// Command stage for the 4-bit ALU: buffers commands, issues them one at a
// time on registered operand ports and holds each result until consumed.
//
// state | meaning
// IDLE  | waiting for a buffered command; pops the head when one exists
// EXEC  | operands on the ALU; result is captured at the next edge
// HOLD  | result held on res_*; waits for res_ready
module alu_cmd_feeder
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_cmd_feeder_if.slave    bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    feeder_state_e   state_q, state_d;
    logic [1:0]      alu_mode_q, alu_mode_d;
    logic [3:0]      alu_a_q, alu_a_d;
    logic [3:0]      alu_b_q, alu_b_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_data_q, res_data_d;
    logic [1:0]      res_mode_q, res_mode_d;

    logic            push;
    logic            pop;
    logic            in_ready;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    alu_cmd_t        push_cmd;
    alu_cmd_t        head_cmd;

    // in_ready comes from the registered occupancy only, so a pop in the
    // same cycle never opens a slot for a push.
    assign in_ready = !fifo_full;
    assign push     = bus.in_valid && in_ready;

    assign push_cmd.mode = bus.in_mode;
    assign push_cmd.a    = bus.in_a;
    assign push_cmd.b    = bus.in_b;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head_cmd),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        alu_mode_d  = alu_mode_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_mode_d  = res_mode_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    alu_mode_d = head_cmd.mode;
                    alu_a_d    = head_cmd.a;
                    alu_b_d    = head_cmd.b;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = bus.alu_out;
                res_mode_d  = alu_mode_q;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_mode_q  <= 2'b00;
            alu_a_q     <= 4'h0;
            alu_b_q     <= 4'h0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_mode_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            alu_mode_q  <= alu_mode_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_mode_q  <= res_mode_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.alu_mode  = alu_mode_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_mode  = res_mode_q;
    assign bus.count     = fifo_count;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_feeder.sv
// Directed bench for alu_cmd_feeder with a behavioural ALU on alu_out and a
// scoreboard of expected {mode, result} checked at each result handshake.
module tb_alu_cmd_feeder;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_res   = 0;

    logic [9:0] sb_q[$];
    int         res_times[$];

    alu_cmd_feeder_if #(.DEPTH(DEPTH)) bus ();

    alu_cmd_feeder #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_model(input logic [1:0] m, input logic [3:0] a,
                                             input logic [3:0] b);
        case (m)
            MODE_ADD: return {4'h0, a} + {4'h0, b};
            MODE_AND: return {4'h0, a & b};
            MODE_GT:  return {7'h00, (a > b)};
            default:  return {4'h0, a >> b};
        endcase
    endfunction

    assign bus.alu_out = alu_model(bus.alu_mode, bus.alu_a, bus.alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            logic [9:0] e;
            n_res++;
            res_times.push_back(cyc);
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("res_data", 32'(bus.res_data), 32'(e[7:0]));
                chk("res_mode", 32'(bus.res_mode), 32'(e[9:8]));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back({m, exp});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("send_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk);
            #1;
            if (bus.count == 0 && !bus.busy && !bus.res_valid) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_data"},  32'(bus.res_data),  32'h00);
        chk({tag, "_res_mode"},  32'(bus.res_mode),  32'd0);
        chk({tag, "_alu_mode"},  32'(bus.alu_mode),  32'd0);
        chk({tag, "_alu_a"},     32'(bus.alu_a),     32'd0);
        chk({tag, "_alu_b"},     32'(bus.alu_b),     32'd0);
        chk({tag, "_count"},     32'(bus.count),     32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    initial begin
        int accepted;
        int k;
        int base;
        bit hit;
        logic [1:0] rm;
        logic [3:0] ra, rb;

        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_a      = 4'h0;
        bus.in_b      = 4'h0;
        bus.res_ready = 1'b0;

        // Power-on reset
        #1 rst = 1'b1;
        #1 chk_reset_values("por");
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single add with cycle-exact timing
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = MODE_ADD;
        bus.in_a      = 4'h9;
        bus.in_b      = 4'h8;
        @(negedge clk);
        chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) sb_q.push_back({MODE_ADD, 8'h11});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("t1_e0_count", 32'(bus.count), 32'd1);
        chk("t1_e0_busy",  32'(bus.busy),  32'd0);
        @(posedge clk);
        #1;
        chk("t1_e1_alu_a",    32'(bus.alu_a),     32'h9);
        chk("t1_e1_alu_b",    32'(bus.alu_b),     32'h8);
        chk("t1_e1_alu_mode", 32'(bus.alu_mode),  32'd0);
        chk("t1_e1_busy",     32'(bus.busy),      32'd1);
        chk("t1_e1_rvalid",   32'(bus.res_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_e2_rvalid", 32'(bus.res_valid), 32'd1);
        chk("t1_e2_rdata",  32'(bus.res_data),  32'h11);
        @(posedge clk);
        #1;
        chk("t1_e3_rvalid", 32'(bus.res_valid), 32'd0);
        chk("t1_e3_alu_a_held", 32'(bus.alu_a), 32'h9);
        wait_drain("t1_drain");

        // One of each remaining op, back to back
        res_times.delete();
        send(MODE_AND, 4'hC, 4'hA, 8'h08);
        send(MODE_GT,  4'h3, 4'h5, 8'h00);
        send(MODE_GT,  4'h7, 4'h2, 8'h01);
        send(MODE_SHR, 4'hF, 4'h2, 8'h03);
        wait_drain("t2_drain");
        chk("t2_nres", 32'(res_times.size()), 32'd4);
        if (res_times.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                chk("t2_spacing", 32'(res_times[i] - res_times[i-1]), 32'd3);
            end
        end
        chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // Backpressure: only 1 + DEPTH are taken while res_ready is low
        bus.res_ready = 1'b0;
        accepted = 0;
        k = 0;
        for (int i = 0; i < 14; i++) begin
            bus.in_valid = 1'b1;
            bus.in_mode  = 2'(k);
            bus.in_a     = 4'(k + 5);
            bus.in_b     = 4'(k + 1);
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back({bus.in_mode, alu_model(bus.in_mode, bus.in_a, bus.in_b)});
                accepted++;
                k++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("t3_accepted", 32'(accepted), 32'd5);
        chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_count",    32'(bus.count),    32'd4);
        chk("t3_rvalid",   32'(bus.res_valid), 32'd1);
        bus.res_ready = 1'b1;
        wait_drain("t3_drain");
        chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // Pointer wrap with random operands
        bus.res_ready = 1'b1;
        base = n_res;
        for (int i = 0; i < 11; i++) begin
            rm = 2'($urandom_range(3, 0));
            ra = 4'($urandom_range(15, 0));
            rb = 4'($urandom_range(15, 0));
            send(rm, ra, rb, alu_model(rm, ra, rb));
        end
        wait_drain("t4_drain");
        chk("t4_nres",     32'(n_res - base), 32'd11);
        chk("t4_count",    32'(bus.count),    32'd0);
        chk("t4_sb_empty", 32'(sb_q.size()),  32'd0);

        // Simultaneous push and pop at COUNT == 2
        bus.res_ready = 1'b0;
        send(MODE_ADD, 4'h2, 4'h3, 8'h05);
        send(MODE_AND, 4'h6, 4'h3, 8'h02);
        send(MODE_SHR, 4'h8, 4'h1, 8'h04);
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (bus.res_valid && bus.count == 2) hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("t5_setup", 32'(hit), 32'd1);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_idle_busy",  32'(bus.busy),  32'd0);
        chk("t5_idle_count", 32'(bus.count), 32'd2);
        bus.in_valid = 1'b1;
        bus.in_mode  = MODE_GT;
        bus.in_a     = 4'h9;
        bus.in_b     = 4'h4;
        @(negedge clk);
        chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) sb_q.push_back({MODE_GT, 8'h01});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("t5_count_same", 32'(bus.count), 32'd2);
        chk("t5_alu_a",      32'(bus.alu_a), 32'h6);
        chk("t5_busy",       32'(bus.busy),  32'd1);
        wait_drain("t5_drain");
        chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset while holding a result with three commands buffered
        bus.res_ready = 1'b0;
        send(MODE_ADD, 4'h1, 4'h2, 8'h03);
        send(MODE_AND, 4'hF, 4'hF, 8'h0F);
        send(MODE_GT,  4'h1, 4'h0, 8'h01);
        send(MODE_SHR, 4'h8, 4'h3, 8'h01);
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (bus.res_valid && bus.count == 3) hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("t6_setup", 32'(hit), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_values("t6_rst");
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.res_ready = 1'b1;
        base = n_res;
        send(MODE_ADD, 4'h1, 4'h1, 8'h02);
        wait_drain("t6_drain");
        chk("t6_nres",     32'(n_res - base), 32'd1);
        chk("t6_sb_empty", 32'(sb_q.size()),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
